// File: rtl/change_dispense_ctrl.sv
// Change dispenser: pays a requested amount with greedy 10/5/1 coins from
// per-denomination inventory, handshaking each coin with the ejector.
module change_dispense_ctrl #(
    parameter int AMT_W       = 8,
    parameter int CNT_W       = 8,
    parameter int INIT_INV    = 20,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             refill_valid,
    input  logic [1:0]       refill_sel,
    input  logic [CNT_W-1:0] refill_count,
    output logic             eject_valid,
    output logic [1:0]       eject_coin,
    input  logic             eject_ack,
    output logic             done,
    output logic [AMT_W-1:0] done_short,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] inv_1,
    output logic [CNT_W-1:0] inv_5,
    output logic [CNT_W-1:0] inv_10
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [1:0] COIN_1  = 2'd0;
    localparam logic [1:0] COIN_5  = 2'd1;
    localparam logic [1:0] COIN_10 = 2'd2;

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] INV_RESET = CNT_W'(INIT_INV);

    state_t           state, state_nxt;
    logic [AMT_W-1:0] rem;
    logic [1:0]       coin;
    logic [1:0]       coin_sel;
    logic             coin_hit;
    logic [TMO_W-1:0] tmo_cnt;
    logic             ack_take;

    function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] c);
        case (c)
            COIN_10: coin_value = AMT_W'(10);
            COIN_5:  coin_value = AMT_W'(5);
            default: coin_value = AMT_W'(1);
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        sat_add = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    assign ack_take = (state == S_EJECT) && eject_ack;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        coin_sel  = COIN_1;
        coin_hit  = 1'b0;
        if (rem >= AMT_W'(10) && inv_10 != '0) begin
            coin_sel = COIN_10;
            coin_hit = 1'b1;
        end else if (rem >= AMT_W'(5) && inv_5 != '0) begin
            coin_sel = COIN_5;
            coin_hit = 1'b1;
        end else if (rem >= AMT_W'(1) && inv_1 != '0) begin
            coin_sel = COIN_1;
            coin_hit = 1'b1;
        end

        case (state)
            S_IDLE:   if (req_valid) state_nxt = S_SELECT;
            S_SELECT: state_nxt = coin_hit ? S_EJECT : S_DONE;
            S_EJECT: begin
                // An ack on the last allowed cycle still wins over the timeout.
                if (eject_ack)                 state_nxt = S_SELECT;
                else if (tmo_cnt == TMO_LAST)  state_nxt = S_FAULT;
            end
            S_DONE:   state_nxt = S_IDLE;
            S_FAULT:  state_nxt = S_FAULT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            rem     <= '0;
            coin    <= COIN_1;
            tmo_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE:   if (req_valid) rem <= req_amount;
                S_SELECT: begin
                    tmo_cnt <= '0;
                    if (coin_hit) coin <= coin_sel;
                end
                S_EJECT: begin
                    if (eject_ack) rem <= rem - coin_value(coin);
                    else           tmo_cnt <= tmo_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Refill and coin decrement never coincide: refill only lands in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            inv_1  <= INV_RESET;
            inv_5  <= INV_RESET;
            inv_10 <= INV_RESET;
        end else if (state == S_IDLE && refill_valid) begin
            case (refill_sel)
                2'd0:    inv_1  <= sat_add(inv_1,  refill_count);
                2'd1:    inv_5  <= sat_add(inv_5,  refill_count);
                2'd2:    inv_10 <= sat_add(inv_10, refill_count);
                default: ;
            endcase
        end else if (ack_take) begin
            case (coin)
                COIN_10: inv_10 <= inv_10 - 1'b1;
                COIN_5:  inv_5  <= inv_5  - 1'b1;
                default: inv_1  <= inv_1  - 1'b1;
            endcase
        end
    end

    assign req_ready   = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign fault       = (state == S_FAULT);
    assign eject_valid = (state == S_EJECT);
    assign eject_coin  = coin;
    assign done        = (state == S_DONE);
    assign done_short  = done ? rem : '0;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Scoreboard bench for change_dispense_ctrl: a greedy inventory model queues
// the expected coin sequence, the ejector emulation pops and compares it.
module tb_change_dispense_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [7:0] req_amount;
    logic       req_ready;
    logic       refill_valid;
    logic [1:0] refill_sel;
    logic [7:0] refill_count;
    logic       eject_valid;
    logic [1:0] eject_coin;
    logic       eject_ack;
    logic       done;
    logic [7:0] done_short;
    logic       busy;
    logic       fault;
    logic [7:0] inv_1, inv_5, inv_10;

    int n_cmp = 0;
    int n_bad = 0;

    int m1, m5, m10;
    logic [1:0] exp_q[$];

    change_dispense_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_amount   (req_amount),
        .req_ready    (req_ready),
        .refill_valid (refill_valid),
        .refill_sel   (refill_sel),
        .refill_count (refill_count),
        .eject_valid  (eject_valid),
        .eject_coin   (eject_coin),
        .eject_ack    (eject_ack),
        .done         (done),
        .done_short   (done_short),
        .busy         (busy),
        .fault        (fault),
        .inv_1        (inv_1),
        .inv_5        (inv_5),
        .inv_10       (inv_10)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m1 = 20; m5 = 20; m10 = 20;
        exp_q.delete();
    endtask

    task automatic model_push(input int amount, output logic [7:0] short_amt);
        int rem;
        rem = amount;
        forever begin
            if (rem >= 10 && m10 > 0)     begin exp_q.push_back(2'd2); rem -= 10; m10--; end
            else if (rem >= 5 && m5 > 0)  begin exp_q.push_back(2'd1); rem -= 5;  m5--;  end
            else if (rem >= 1 && m1 > 0)  begin exp_q.push_back(2'd0); rem -= 1;  m1--;  end
            else break;
        end
        short_amt = 8'(rem);
    endtask

    task automatic do_refill(input logic [1:0] sel, input logic [7:0] cnt);
        @(negedge clk);
        refill_valid = 1'b1; refill_sel = sel; refill_count = cnt;
        @(posedge clk);
        #1 refill_valid = 1'b0;
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic check_inv(input string tag);
        n_cmp++;
        if (inv_1 !== 8'(m1) || inv_5 !== 8'(m5) || inv_10 !== 8'(m10)) begin
            n_bad++;
            $display("FAIL %s inventory: got %0d/%0d/%0d, want %0d/%0d/%0d",
                     tag, inv_1, inv_5, inv_10, m1, m5, m10);
        end
    endtask

    // Drives one request and plays the ejector, acking each coin after
    // ack_delay cycles; coins and shortfall are checked against the queue.
    task automatic drive_request(input int amount, input int ack_delay);
        logic [7:0] exp_short;
        logic [1:0] exp_coin, seen;
        int  cyc;
        bit  first, finished;
        model_push(amount, exp_short);
        @(negedge clk);
        req_valid = 1'b1; req_amount = 8'(amount);
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0; first = 1'b1; finished = 1'b0;
        while (!finished && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (first && (eject_valid || done)) begin
                first = 1'b0;
                n_cmp++;
                if (cyc != 2) begin
                    n_bad++;
                    $display("FAIL latency req=%0d: first response at cycle %0d, want 2", amount, cyc);
                end
            end
            if (eject_valid) begin
                seen = eject_coin;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra_eject req=%0d: coin %0d, want none", amount, seen);
                end else begin
                    exp_coin = exp_q.pop_front();
                    if (seen !== exp_coin) begin
                        n_bad++;
                        $display("FAIL coin req=%0d: got %0d, want %0d", amount, seen, exp_coin);
                    end
                end
                repeat (ack_delay) @(negedge clk);
                n_cmp++;
                if (eject_valid !== 1'b1 || eject_coin !== seen) begin
                    n_bad++;
                    $display("FAIL eject_hold req=%0d: valid=%b coin=%0d, want 1/%0d",
                             amount, eject_valid, eject_coin, seen);
                end
                eject_ack = 1'b1;
                @(posedge clk);
                #1 eject_ack = 1'b0;
            end else if (done) begin
                finished = 1'b1;
                n_cmp++;
                if (done_short !== exp_short) begin
                    n_bad++;
                    $display("FAIL done_short req=%0d: got %0d, want %0d", amount, done_short, exp_short);
                end
                n_cmp++;
                if (exp_q.size() != 0) begin
                    n_bad++;
                    $display("FAIL missing_coins req=%0d: %0d left, want 0", amount, exp_q.size());
                end
            end
        end
        if (!finished) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout req=%0d: no done within %0d cycles, want done", amount, cyc);
            exp_q.delete();
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL after_done req=%0d: done=%b ready=%b, want 0/1", amount, done, req_ready);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_cmp++;
        if (eject_valid !== 1'b0 || eject_coin !== 2'd0 || done !== 1'b0 ||
            done_short !== 8'd0 || fault !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_outputs: ev=%b coin=%0d done=%b short=%0d fault=%b busy=%b ready=%b, want 0 0 0 0 0 0 1",
                     eject_valid, eject_coin, done, done_short, fault, busy, req_ready);
        end
        check_inv("reset");
    endtask

    task automatic test_greedy();
        drive_request(35, 1);
        check_inv("greedy_35");
        n_cmp++;
        if (inv_10 !== 8'd17 || inv_5 !== 8'd19) begin
            n_bad++;
            $display("FAIL greedy_35_fixed: inv_10=%0d inv_5=%0d, want 17/19", inv_10, inv_5);
        end
    endtask

    task automatic test_no_tens();
        drive_request(170, 0);
        check_inv("drain_tens");
        drive_request(23, 2);
        check_inv("no_tens_23");
    endtask

    task automatic test_shortfall();
        drive_request(m5 * 5, 0);
        drive_request(m1, 0);
        check_inv("drain_all");
        drive_request(7, 1);
        check_inv("short_7");
    endtask

    task automatic test_zero();
        apply_reset();
        drive_request(0, 0);
        check_inv("zero");
    endtask

    task automatic test_back_to_back();
        drive_request(16, 3);
        drive_request(9, 0);
        drive_request(1, 5);
        check_inv("back_to_back");
    endtask

    task automatic test_refill();
        int cyc;
        apply_reset();
        do_refill(2'd2, 8'd250); m10 = sat(m10 + 250);
        do_refill(2'd0, 8'd5);   m1  = sat(m1 + 5);
        do_refill(2'd3, 8'd9);
        @(negedge clk);
        check_inv("refill");
        n_cmp++;
        if (inv_10 !== 8'd255) begin
            n_bad++;
            $display("FAIL refill_saturate: inv_10=%0d, want 255", inv_10);
        end
        // Refill together with a zero-amount request: both take effect.
        @(negedge clk);
        req_valid = 1'b1; req_amount = 8'd0;
        refill_valid = 1'b1; refill_sel = 2'd1; refill_count = 8'd4;
        @(posedge clk);
        #1 req_valid = 1'b0; refill_valid = 1'b0;
        m5 = sat(m5 + 4);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || done_short !== 8'd0) begin
            n_bad++;
            $display("FAIL refill_with_req: done=%b short=%0d, want 1/0", done, done_short);
        end
        check_inv("refill_with_req");
        // Refill while busy is dropped.
        @(negedge clk);
        req_valid = 1'b1; req_amount = 8'd1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0;
        while (eject_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        refill_valid = 1'b1; refill_sel = 2'd1; refill_count = 8'd3;
        @(posedge clk);
        #1 refill_valid = 1'b0;
        @(negedge clk);
        eject_ack = 1'b1;
        @(posedge clk);
        #1 eject_ack = 1'b0;
        m1--;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL refill_busy_done: done=%b, want 1", done);
        end
        @(negedge clk);
        check_inv("refill_busy");
    endtask

    task automatic test_timeout();
        int cyc, hi;
        apply_reset();
        @(negedge clk);
        req_valid = 1'b1; req_amount = 8'd10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0;
        while (eject_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        hi = 0;
        while (eject_valid === 1'b1 && hi < 100) begin hi++; @(negedge clk); end
        n_cmp++;
        if (hi != 16) begin
            n_bad++;
            $display("FAIL timeout_len: eject_valid high %0d cycles, want 16", hi);
        end
        n_cmp++;
        if (fault !== 1'b1 || eject_valid !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL fault_state: fault=%b ev=%b ready=%b busy=%b, want 1 0 0 1",
                     fault, eject_valid, req_ready, busy);
        end
        eject_ack = 1'b1; req_valid = 1'b1; req_amount = 8'd5;
        repeat (3) @(posedge clk);
        #1 eject_ack = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fault !== 1'b1 || eject_valid !== 1'b0 || inv_10 !== 8'd20) begin
            n_bad++;
            $display("FAIL fault_sticky: fault=%b ev=%b inv_10=%0d, want 1 0 20", fault, eject_valid, inv_10);
        end
        apply_reset();
        @(negedge clk);
        n_cmp++;
        if (fault !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL fault_clear: fault=%b ready=%b, want 0/1", fault, req_ready);
        end
    endtask

    task automatic test_reset_abort();
        int cyc;
        bit saw_done;
        @(negedge clk);
        req_valid = 1'b1; req_amount = 8'd35;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0;
        while (eject_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        eject_ack = 1'b1;
        @(posedge clk);
        #1 eject_ack = 1'b0;
        apply_reset();
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1 || eject_valid === 1'b1) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_abort: activity=%b busy=%b, want 0/0", saw_done, busy);
        end
        check_inv("reset_abort");
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_amount = '0; refill_valid = 1'b0;
        refill_sel = '0; refill_count = '0; eject_ack = 1'b0;
        test_reset();
        test_greedy();
        test_no_tens();
        test_shortfall();
        test_zero();
        test_back_to_back();
        test_refill();
        test_timeout();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
